adc_pmod: RTL and testbench

ADC_PMOD -- requirements
Module: adc_pmod

---
 rtl/adc_pmod_pkg.sv | 41 ++++
 rtl/adc_pmod_shifter.sv | 33 +++
 rtl/adc_pmod.sv | 141 ++++++++++++++
 tb/tb_adc_pmod.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pmod_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_pmod_pkg: shared types, byte order and sample conversion     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package adc_pmod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUSH    = 2'd2
  } state_t;

  localparam int c_sample_bits  = 16;
  localparam int c_half_periods = 32;

  // Byte slot order on the FIFO port, same LR layout as the DAC path
  localparam logic [1:0] c_byte_l_lo = 2'd0;
  localparam logic [1:0] c_byte_l_hi = 2'd1;
  localparam logic [1:0] c_byte_r_lo = 2'd2;
  localparam logic [1:0] c_byte_r_hi = 2'd3;

  function automatic logic [15:0] offset_to_twos(input logic [11:0] code);
    return {~code[11], code[10:0], 4'b0000};
  endfunction

  function automatic logic [7:0] select_byte(input logic [1:0]  idx,
                                             input logic [15:0] left,
                                             input logic [15:0] right);
    logic [7:0] result;
    case (idx)
      c_byte_l_lo: result = left[7:0];
      c_byte_l_hi: result = left[15:8];
      c_byte_r_lo: result = right[7:0];
      default:     result = right[15:8];
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_pmod_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_pmod_shifter: dual 16-bit MSB-first capture shift register   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module adc_pmod_shifter
  import adc_pmod_pkg::*;
(
  input  logic                     clk_selected,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     capture,
  input  logic                     sdata0,
  input  logic                     sdata1,
  output logic [c_sample_bits-1:0] word0,
  output logic [c_sample_bits-1:0] word1
);

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      word0 <= '0;
      word1 <= '0;
    end else if (clear) begin
      word0 <= '0;
      word1 <= '0;
    end else if (capture) begin
      word0 <= {word0[c_sample_bits-2:0], sdata0};
      word1 <= {word1[c_sample_bits-2:0], sdata1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_pmod.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_pmod: PMOD-AD1 dual-channel frame sampler feeding byte FIFO  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module adc_pmod
  import adc_pmod_pkg::*;
#(
  parameter int CLKDIV_LOG2  = 2,
  parameter int FRAME_CYCLES = 256,
  parameter int QUIET_CYCLES = 4
) (
  input  logic       clk_selected,
  input  logic       reset,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_sdata0,
  input  logic       adc_sdata1,
  output logic [7:0] fifo_data,
  output logic       fifo_write,
  input  logic       fifo_full,
  output logic [7:0] overflow_count
);

  localparam int c_half    = 1 << CLKDIV_LOG2;
  localparam int c_div_w   = (CLKDIV_LOG2 > 0) ? CLKDIV_LOG2 : 1;
  localparam int c_frame_w = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(c_half - 1);
  localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(FRAME_CYCLES - 1);

  generate
    if (FRAME_CYCLES < c_half_periods * c_half + 4 + QUIET_CYCLES) begin : g_frame_too_short
      $error("adc_pmod: FRAME_CYCLES too small for conversion, push and quiet time");
    end
  endgenerate

  state_t                    r_state;
  logic [c_frame_w-1:0]      r_frame_cnt;
  logic [c_div_w-1:0]        r_div;
  logic [4:0]                r_half;
  logic [1:0]                r_byte;
  logic [c_sample_bits-1:0]  w_word0;
  logic [c_sample_bits-1:0]  w_word1;
  logic [15:0]               w_left;
  logic [15:0]               w_right;
  logic                      w_start;
  logic                      w_capture;
  logic                      w_unused_lead;

  assign w_start   = (r_state == ST_IDLE) && (r_frame_cnt == '0) && enable;
  // The edge that ends a low half-period raises SCLK and samples the data line
  assign w_capture = (r_state == ST_CONVERT) && (r_div == c_div_last) && !adc_sclk;

  adc_pmod_shifter u_shifter (
    .clk_selected (clk_selected),
    .reset        (reset),
    .clear        (w_start),
    .capture      (w_capture),
    .sdata0       (adc_sdata0),
    .sdata1       (adc_sdata1),
    .word0        (w_word0),
    .word1        (w_word1)
  );

  assign w_left        = offset_to_twos(w_word0[11:0]);
  assign w_right       = offset_to_twos(w_word1[11:0]);
  assign w_unused_lead = ^{w_word0[15:12], w_word1[15:12]};

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_frame_cnt == c_frame_last) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + c_frame_w'(1);
    end
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      adc_cs_n       <= 1'b1;
      adc_sclk       <= 1'b1;
      fifo_write     <= 1'b0;
      fifo_data      <= 8'h00;
      overflow_count <= 8'h00;
      r_div          <= '0;
      r_half         <= 5'd0;
      r_byte         <= 2'd0;
    end else begin
      fifo_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_CONVERT;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            r_div    <= '0;
            r_half   <= 5'd0;
          end
        end
        ST_CONVERT: begin
          if (r_div == c_div_last) begin
            r_div  <= '0;
            r_half <= r_half + 5'd1;
            // Last high half-period done: release the converter in one step
            if (r_half == 5'(c_half_periods - 1)) begin
              adc_cs_n <= 1'b1;
              adc_sclk <= 1'b1;
              r_byte   <= 2'd0;
              r_state  <= ST_PUSH;
            end else begin
              adc_sclk <= ~adc_sclk;
            end
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        ST_PUSH: begin
          if ((r_byte == 2'd0) && fifo_full) begin
            if (overflow_count != 8'hFF) begin
              overflow_count <= overflow_count + 8'd1;
            end
            r_state <= ST_IDLE;
          end else begin
            fifo_write <= 1'b1;
            fifo_data  <= select_byte(r_byte, w_left, w_right);
            r_byte     <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_pmod.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_adc_pmod: scoreboard bench for adc_pmod with a PMOD-AD1 model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_adc_pmod;

  logic       clk_selected = 1'b0;
  logic       reset;
  logic       enable;
  logic       adc_sdata0;
  logic       adc_sdata1;
  logic       fifo_full;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] fifo_data;
  logic       fifo_write;
  logic [7:0] overflow_count;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0]  exp_q[$];
  logic [11:0] m_ch0 = 12'h000;
  logic [11:0] m_ch1 = 12'h000;

  adc_pmod dut (
    .clk_selected   (clk_selected),
    .reset          (reset),
    .enable         (enable),
    .adc_cs_n       (adc_cs_n),
    .adc_sclk       (adc_sclk),
    .adc_sdata0     (adc_sdata0),
    .adc_sdata1     (adc_sdata1),
    .fifo_data      (fifo_data),
    .fifo_write     (fifo_write),
    .fifo_full      (fifo_full),
    .overflow_count (overflow_count)
  );

  always #5 clk_selected = ~clk_selected;
  always @(posedge clk_selected) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  // Converter model: leading zeros then 12-bit code, next bit 1 unit after each SCLK rise
  initial begin
    logic [15:0] w0, w1;
    logic        pcs, psclk;
    int          idx;
    w0 = '0; w1 = '0; pcs = 1'b1; psclk = 1'b1; idx = -1;
    adc_sdata0 = 1'b0;
    adc_sdata1 = 1'b0;
    forever begin
      @(posedge clk_selected);
      #1;
      if (pcs && !adc_cs_n) begin
        w0  = {4'h0, m_ch0};
        w1  = {4'h0, m_ch1};
        idx = 15;
      end else if (!adc_cs_n && !psclk && adc_sclk) begin
        idx--;
      end
      if (!adc_cs_n && idx >= 0) begin
        adc_sdata0 = w0[idx];
        adc_sdata1 = w1[idx];
      end else begin
        adc_sdata0 = 1'b0;
        adc_sdata1 = 1'b0;
      end
      pcs   = adc_cs_n;
      psclk = adc_sclk;
    end
  end

  // Scoreboard monitor
  initial begin
    int         run;
    logic [7:0] e;
    logic [7:0] last;
    run = 0;
    last = 8'h00;
    forever begin
      @(negedge clk_selected);
      if (fifo_write) begin
        run++;
        last = fifo_data;
        if (exp_q.size() == 0) begin
          check("write_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("fifo_byte", fifo_data, e);
        end
      end else if (run != 0) begin
        check("burst_len", run, 4);
        check("data_hold", fifo_data, last);
        run = 0;
      end
    end
  end

  task automatic wait_cs(input logic lvl, input int budget, output int n);
    n = 0;
    while (adc_cs_n !== lvl && n < budget) begin
      @(negedge clk_selected);
      n++;
    end
    if (adc_cs_n !== lvl) begin
      check("wait_cs_timeout", adc_cs_n, lvl);
      n = -1;
    end
  endtask

  task automatic measure_low(output int low, output int rises, output int fall_cyc);
    logic prev;
    fall_cyc = cyc;
    low   = 0;
    rises = 0;
    prev  = adc_sclk;
    while (adc_cs_n == 1'b0 && low < 1000) begin
      low++;
      @(negedge clk_selected);
      if (!prev && adc_sclk && !adc_cs_n) rises++;
      prev = adc_sclk;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, low, rises, f1, f2, f3, f4, falls, rcnt;
    logic prev;
    reset = 1'b1; enable = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk_selected);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_write", fifo_write, 0);
    check("rst_data", fifo_data, 0);
    check("rst_ovf", overflow_count, 0);

    // Frame 1: full-scale left, zero-scale right; starts on first edge after release
    m_ch0 = 12'hFFF; m_ch1 = 12'h000;
    push_bytes(8'hF0, 8'h7F, 8'h00, 8'h80);
    reset = 1'b0; enable = 1'b1;
    wait_cs(1'b0, 2, n);
    check("first_frame_latency", n, 1);
    measure_low(low, rises, f1);
    check("cs_low_cycles", low, 128);
    check("sclk_rises", rises, 16);

    // Frame 2: mid-scale codes; fifo_full raised mid-burst must be ignored
    m_ch0 = 12'h800; m_ch1 = 12'h801;
    push_bytes(8'h00, 8'h00, 8'h10, 8'h00);
    wait_cs(1'b0, 300, n);
    check("quiet_ok", int'(n >= 4), 1);
    measure_low(low, rises, f2);
    check("frame_period", f2 - f1, 256);
    check("cs_low_cycles2", low, 128);
    check("sclk_rises2", rises, 16);
    n = 0;
    while (!fifo_write && n < 10) begin @(negedge clk_selected); n++; end
    check("burst_started", fifo_write, 1);
    fifo_full = 1'b1;
    repeat (6) @(negedge clk_selected);
    fifo_full = 1'b0;

    // Frame 3: enable dropped during CONVERT still completes
    m_ch0 = 12'h123; m_ch1 = 12'hABC;
    push_bytes(8'h30, 8'h92, 8'hC0, 8'h2B);
    wait_cs(1'b0, 300, n);
    f3 = cyc;
    repeat (20) @(negedge clk_selected);
    enable = 1'b0;
    wait_cs(1'b1, 200, n);
    falls = 0;
    prev  = adc_cs_n;
    repeat (600) begin
      @(negedge clk_selected);
      if (prev && !adc_cs_n) falls++;
      prev = adc_cs_n;
    end
    check("no_frame_disabled", falls, 0);

    // Frame 4: re-enable, must realign to frame counter zero
    m_ch0 = 12'h000; m_ch1 = 12'hFFF;
    push_bytes(8'h00, 8'h80, 8'hF0, 8'h7F);
    enable = 1'b1;
    wait_cs(1'b0, 300, n);
    f4 = cyc;
    check("realign", (f4 - f3) % 256, 0);
    wait_cs(1'b1, 200, n);
    repeat (8) @(negedge clk_selected);

    // Overflow: drops saturate at 255, then writing resumes
    fifo_full = 1'b1;
    for (int i = 0; i < 258; i++) begin
      wait_cs(1'b0, 300, n);
      wait_cs(1'b1, 200, n);
      if (i == 0) begin
        repeat (2) @(negedge clk_selected);
        check("ovf_first", overflow_count, 1);
      end
    end
    repeat (3) @(negedge clk_selected);
    check("ovf_saturated", overflow_count, 255);
    fifo_full = 1'b0;
    m_ch0 = 12'h7FF; m_ch1 = 12'h001;
    push_bytes(8'hF0, 8'hFF, 8'h10, 8'h80);
    wait_cs(1'b0, 300, n);
    wait_cs(1'b1, 200, n);
    repeat (8) @(negedge clk_selected);
    check("ovf_held", overflow_count, 255);

    // Reset at the 8th SCLK rise: frame aborted, nothing written for it
    m_ch0 = 12'hFFF; m_ch1 = 12'hFFF;
    wait_cs(1'b0, 300, n);
    rcnt = 0;
    prev = adc_sclk;
    n = 0;
    while (rcnt < 8 && n < 200) begin
      @(negedge clk_selected);
      if (!prev && adc_sclk) rcnt++;
      prev = adc_sclk;
      n++;
    end
    check("reached_8th_rise", rcnt, 8);
    reset = 1'b1;
    #1;
    check("async_rst_cs_n", adc_cs_n, 1);
    check("async_rst_sclk", adc_sclk, 1);
    check("async_rst_data", fifo_data, 0);
    check("async_rst_ovf", overflow_count, 0);
    repeat (3) @(negedge clk_selected);
    check("rst_no_write", fifo_write, 0);
    m_ch0 = 12'h800; m_ch1 = 12'h801;
    push_bytes(8'h00, 8'h00, 8'h10, 8'h00);
    reset = 1'b0;
    wait_cs(1'b0, 2, n);
    check("restart_latency", n, 1);
    measure_low(low, rises, f1);
    check("cs_low_after_rst", low, 128);
    repeat (10) @(negedge clk_selected);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
